fb_vga_reader: RTL

FB_VGA_READER -- requirements
Module: fb_vga_reader

---
 rtl/fb_vga_pkg.sv | 58 +++++
 rtl/fb_vga_reader_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 46 ++++
 rtl/fb_vga_reader.sv | 89 ++++++++
 4 files changed

// File: rtl/fb_vga_pkg.sv
// Shared 640x480@60 timing constants, pipeline depth and framebuffer geometry helpers
// for the grayscale framebuffer-to-VGA reader.
package fb_vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned PIPE_LAT = 3;

    localparam int unsigned DIM_W  = 10;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 8;

    // Per-frame window geometry; x1/y1 are exclusive bounds.
    typedef struct packed {
        logic             valid;
        logic [DIM_W-1:0] x0;
        logic [DIM_W-1:0] x1;
        logic [DIM_W-1:0] y0;
        logic [DIM_W-1:0] y1;
    } geom_t;

    // Timing flags carried down the pipeline alongside the read address.
    typedef struct packed {
        logic active;
        logic win;
        logic hsync;
        logic vsync;
        logic fs;
    } flags_t;

    localparam flags_t FLAGS_RST = '{active: 1'b0, win: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                     fs: 1'b0};

    function automatic geom_t calc_geom(input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h,
                                        input logic [31:0] max_addr);
        geom_t      g;
        logic [19:0] area;
        area    = {10'd0, w} * {10'd0, h};
        g.valid = (w != '0) && (h != '0) && (w <= DIM_W'(H_ACTIVE)) &&
                  (h <= DIM_W'(V_ACTIVE)) && (32'(area) <= max_addr + 32'd1);
        g.x0    = (DIM_W'(H_ACTIVE) - w) >> 1;
        g.y0    = (DIM_W'(V_ACTIVE) - h) >> 1;
        g.x1    = g.x0 + w;
        g.y1    = g.y0 + h;
        return g;
    endfunction

endpackage

// File: rtl/fb_vga_reader_if.sv
// Framebuffer read port, image size inputs and VGA pin bundle of the reader.
interface fb_vga_reader_if;
    import fb_vga_pkg::*;

    logic [DIM_W-1:0]  img_w;
    logic [DIM_W-1:0]  img_h;
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [PIX_W-1:0]  ram_rddata;
    logic [PIX_W-1:0]  vga_r;
    logic [PIX_W-1:0]  vga_g;
    logic [PIX_W-1:0]  vga_b;
    logic              hsync;
    logic              vsync;
    logic              blank_n;
    logic              frame_start;

    modport master (
        input  img_w, img_h, ram_rddata,
        output ram_rdaddr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start
    );

    modport slave (
        output img_w, img_h, ram_rddata,
        input  ram_rdaddr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start
    );

endinterface

// File: rtl/vga_timing_gen.sv
// 800x525 horizontal/vertical counters with raw (unregistered) sync, active and
// frame-start decode; this is stage 0 of the reader pipeline.
module vga_timing_gen
    import fb_vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [DIM_W-1:0] h_o,
    output logic [DIM_W-1:0] v_o,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o
);

    logic [DIM_W-1:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == DIM_W'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == DIM_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign active_o      = (h_q < DIM_W'(H_ACTIVE)) && (v_q < DIM_W'(V_ACTIVE));
    assign hsync_o       = !((h_q >= DIM_W'(H_ACTIVE + H_FP)) &&
                             (h_q < DIM_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_o       = !((v_q >= DIM_W'(V_ACTIVE + V_FP)) &&
                             (v_q < DIM_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/fb_vga_reader.sv
// Streams a centred img_w x img_h grayscale image from a synchronous framebuffer RAM
// to VGA pins, surrounded by a constant border colour.
module fb_vga_reader
    import fb_vga_pkg::*;
#(
    parameter int unsigned      IMG_MAX_ADDR = 524287,
    parameter logic [PIX_W-1:0] BORDER       = 8'h00
) (
    input logic             clk,
    input logic             reset,
    fb_vga_reader_if.master fb
);

    logic [DIM_W-1:0]  h, v;
    logic              active, hsync_raw, vsync_raw, frame_start_raw;
    geom_t             geo_q, geo_d, geo_cur;
    logic              in_win;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, addr_base, rdaddr_q, rdaddr_d;
    flags_t            s1_q, s1_d, s2_q, s2_d, out_q, out_d;
    logic [PIX_W-1:0]  pix_q, pix_d;

    vga_timing_gen u_timing (
        .clk          (clk),
        .reset        (reset),
        .h_o          (h),
        .v_o          (v),
        .active_o     (active),
        .hsync_o      (hsync_raw),
        .vsync_o      (vsync_raw),
        .frame_start_o(frame_start_raw)
    );

    always_comb begin
        // The frame-start pixel itself already uses the freshly latched size.
        geo_cur = frame_start_raw ? calc_geom(fb.img_w, fb.img_h, 32'(IMG_MAX_ADDR)) : geo_q;
        geo_d   = geo_cur;
        in_win  = geo_cur.valid && (h >= geo_cur.x0) && (h < geo_cur.x1) &&
                  (v >= geo_cur.y0) && (v < geo_cur.y1);

        addr_base  = frame_start_raw ? '0 : addr_cnt_q;
        addr_cnt_d = addr_base;
        rdaddr_d   = rdaddr_q;
        if (in_win) begin
            rdaddr_d   = addr_base;
            addr_cnt_d = addr_base + 1'b1;
        end else if (frame_start_raw && !geo_cur.valid) begin
            rdaddr_d = '0;
        end

        s1_d  = '{active: active, win: in_win, hsync: hsync_raw, vsync: vsync_raw,
                  fs: frame_start_raw};
        s2_d  = s1_q;
        out_d = s2_q;
        pix_d = '0;
        if (s2_q.active) begin
            pix_d = s2_q.win ? fb.ram_rddata : BORDER;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            geo_q      <= '0;
            addr_cnt_q <= '0;
            rdaddr_q   <= '0;
            s1_q       <= FLAGS_RST;
            s2_q       <= FLAGS_RST;
            out_q      <= FLAGS_RST;
            pix_q      <= '0;
        end else begin
            geo_q      <= geo_d;
            addr_cnt_q <= addr_cnt_d;
            rdaddr_q   <= rdaddr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_q      <= out_d;
            pix_q      <= pix_d;
        end
    end

    assign fb.ram_rdaddr  = rdaddr_q;
    assign fb.vga_r       = pix_q;
    assign fb.vga_g       = pix_q;
    assign fb.vga_b       = pix_q;
    assign fb.hsync       = out_q.hsync;
    assign fb.vsync       = out_q.vsync;
    assign fb.blank_n     = out_q.active;
    assign fb.frame_start = out_q.fs;

endmodule
